// File: rtl/alu_system_control_unit_if.sv
// Control bus between the sequencer and the ALU system datapath.
// The sequencer is the master: it reads IR contents and flags and drives every control field.
interface alu_system_control_unit_if;
  // Datapath status seen by the sequencer
  logic [15:0] ir_out;
  logic [3:0]  flags;

  // Register file controls (selects are active-low)
  logic [2:0]  rf_out_a_sel;
  logic [2:0]  rf_out_b_sel;
  logic [2:0]  rf_fun_sel;
  logic [3:0]  rf_reg_sel;
  logic [3:0]  rf_scr_sel;

  logic [4:0]  alu_fun_sel;
  logic        alu_wf;

  // Address register file controls: {PC,SP,AR}
  logic [1:0]  arf_out_c_sel;
  logic [1:0]  arf_out_d_sel;
  logic [2:0]  arf_fun_sel;
  logic [2:0]  arf_reg_sel;

  logic        ir_lh;
  logic        ir_write;
  logic        mem_wr;
  logic        mem_cs;
  logic [1:0]  mux_a_sel;
  logic [1:0]  mux_b_sel;
  logic        mux_c_sel;

  modport master (
    input  ir_out, flags,
    output rf_out_a_sel, rf_out_b_sel, rf_fun_sel, rf_reg_sel, rf_scr_sel,
           alu_fun_sel, alu_wf,
           arf_out_c_sel, arf_out_d_sel, arf_fun_sel, arf_reg_sel,
           ir_lh, ir_write, mem_wr, mem_cs, mux_a_sel, mux_b_sel, mux_c_sel
  );

  modport slave (
    output ir_out, flags,
    input  rf_out_a_sel, rf_out_b_sel, rf_fun_sel, rf_reg_sel, rf_scr_sel,
           alu_fun_sel, alu_wf,
           arf_out_c_sel, arf_out_d_sel, arf_fun_sel, arf_reg_sel,
           ir_lh, ir_write, mem_wr, mem_cs, mux_a_sel, mux_b_sel, mux_c_sel
  );
endinterface

// File: rtl/alu_system_control_unit.sv
// Four-phase sequencer (fetch low byte, fetch high byte, decode, execute) for the ALU system.
// Control outputs are a purely combinational decode of the phase register, IR contents and flags.
module alu_system_control_unit (
  input  logic                              clk_i,
  input  logic                              rst_i,
  alu_system_control_unit_if.master         bus,
  output logic [1:0]                        t_o,
  output logic                              halted_o,
  output logic                              illegal_o
);

  localparam logic [2:0] FUN_LOAD  = 3'b010;
  localparam logic [2:0] FUN_INC   = 3'b001;
  localparam logic [2:0] FUN_CLEAR = 3'b011;
  localparam logic [4:0] ALU_PASSA = 5'b10000;
  localparam logic [4:0] ALU_ADD   = 5'b10100;
  localparam logic [4:0] ALU_SUB   = 5'b10101;

  typedef enum logic [1:0] {
    FETCH_L = 2'd0,
    FETCH_H = 2'd1,
    DECODE  = 2'd2,
    EXEC    = 2'd3
  } state_e;

  typedef enum logic [3:0] {
    OP_NOP  = 4'h0,
    OP_LDI  = 4'h1,
    OP_ADD  = 4'h2,
    OP_SUB  = 4'h3,
    OP_BNE  = 4'h4,
    OP_ST   = 4'h5,
    OP_LD   = 4'h6,
    OP_LDAR = 4'h7,
    OP_HLT  = 4'hF
  } op_e;

  state_e     state_q, state_d;
  logic       halted_q, halted_d;

  op_e        op;
  logic [1:0] rd;
  logic [1:0] rs;
  logic       flag_z;

  assign op     = op_e'(bus.ir_out[15:12]);
  assign rd     = bus.ir_out[11:10];
  assign rs     = bus.ir_out[9:8];
  assign flag_z = bus.flags[3];

  // The immediate and the C/N/O flags are consumed by the datapath, not the sequencer.
  logic unused_bits;
  assign unused_bits = ^{bus.ir_out[7:0], bus.flags[2:0]};

  // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= FETCH_L;
      halted_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      halted_q <= halted_d;
    end
  end

  // NOTE: every combinational output gets a default first so no path can infer a latch.
  always_comb begin
    state_d  = state_q;
    halted_d = halted_q;
    if (!halted_q) begin
      unique case (state_q)
        FETCH_L: state_d = FETCH_H;
        FETCH_H: state_d = DECODE;
        DECODE:  state_d = EXEC;
        EXEC: begin
          state_d = FETCH_L;
          if (op == OP_HLT) halted_d = 1'b1;
        end
        default: state_d = FETCH_L;
      endcase
    end
  end

  always_comb begin
    // IDLE word
    bus.rf_out_a_sel  = 3'd0;
    bus.rf_out_b_sel  = 3'd0;
    bus.rf_fun_sel    = 3'd0;
    bus.rf_reg_sel    = 4'b1111;
    bus.rf_scr_sel    = 4'b1111;
    bus.alu_fun_sel   = 5'd0;
    bus.alu_wf        = 1'b0;
    bus.arf_out_c_sel = 2'd0;
    bus.arf_out_d_sel = 2'd0;
    bus.arf_fun_sel   = 3'd0;
    bus.arf_reg_sel   = 3'b111;
    bus.ir_lh         = 1'b0;
    bus.ir_write      = 1'b0;
    bus.mem_wr        = 1'b0;
    bus.mem_cs        = 1'b1;
    bus.mux_a_sel     = 2'd0;
    bus.mux_b_sel     = 2'd0;
    bus.mux_c_sel     = 1'b0;
    illegal_o         = 1'b0;

    if (rst_i) begin
      // Clear every datapath register while reset is held; overrides any in-flight store.
      bus.rf_reg_sel  = 4'b0000;
      bus.rf_scr_sel  = 4'b0000;
      bus.arf_reg_sel = 3'b000;
      bus.rf_fun_sel  = FUN_CLEAR;
      bus.arf_fun_sel = FUN_CLEAR;
    end else if (!halted_q) begin
      unique case (state_q)
        FETCH_L, FETCH_H: begin
          bus.arf_out_d_sel = 2'b00;
          bus.mem_cs        = 1'b0;
          bus.ir_write      = 1'b1;
          bus.ir_lh         = (state_q == FETCH_H);
          bus.arf_reg_sel   = 3'b011;
          bus.arf_fun_sel   = FUN_INC;
        end
        DECODE: ;
        EXEC: begin
          case (op)
            OP_NOP, OP_HLT: ;
            OP_LDI: begin
              bus.mux_a_sel  = 2'b11;
              bus.rf_fun_sel = FUN_LOAD;
              bus.rf_reg_sel = ~(4'b0001 << rd);
            end
            OP_ADD, OP_SUB: begin
              bus.rf_out_a_sel = {1'b0, rd};
              bus.rf_out_b_sel = {1'b0, rs};
              bus.alu_fun_sel  = (op == OP_ADD) ? ALU_ADD : ALU_SUB;
              bus.alu_wf       = 1'b1;
              bus.mux_a_sel    = 2'b00;
              bus.rf_fun_sel   = FUN_LOAD;
              bus.rf_reg_sel   = ~(4'b0001 << rd);
            end
            OP_BNE: begin
              if (!flag_z) begin
                bus.mux_b_sel   = 2'b11;
                bus.arf_fun_sel = FUN_LOAD;
                bus.arf_reg_sel = 3'b011;
              end
            end
            OP_ST: begin
              bus.rf_out_a_sel  = {1'b0, rd};
              bus.alu_fun_sel   = ALU_PASSA;
              bus.mux_c_sel     = 1'b0;
              bus.arf_out_d_sel = 2'b10;
              bus.mem_cs        = 1'b0;
              bus.mem_wr        = 1'b1;
            end
            OP_LD: begin
              bus.arf_out_d_sel = 2'b10;
              bus.mem_cs        = 1'b0;
              bus.mux_a_sel     = 2'b10;
              bus.rf_fun_sel    = FUN_LOAD;
              bus.rf_reg_sel    = ~(4'b0001 << rd);
            end
            OP_LDAR: begin
              bus.mux_b_sel   = 2'b11;
              bus.arf_fun_sel = FUN_LOAD;
              bus.arf_reg_sel = 3'b110;
            end
            default: illegal_o = 1'b1;
          endcase
        end
        default: ;
      endcase
    end
  end

  assign t_o      = state_q;
  assign halted_o = halted_q;

endmodule

// File: tb/tb_alu_system_control_unit.sv
// Randomized scoreboard bench: the stimulus side predicts each cycle's control word from the
// instruction-level rules and queues it; a negedge monitor pops and compares against the DUT.
module tb_alu_system_control_unit;

  typedef struct packed {
    logic [2:0] rf_a;
    logic [2:0] rf_b;
    logic [2:0] rf_fun;
    logic [3:0] rf_reg;
    logic [3:0] rf_scr;
    logic [4:0] alu_fun;
    logic       alu_wf;
    logic [1:0] arf_c;
    logic [1:0] arf_d;
    logic [2:0] arf_fun;
    logic [2:0] arf_reg;
    logic       ir_lh;
    logic       ir_write;
    logic       mem_wr;
    logic       mem_cs;
    logic [1:0] mux_a;
    logic [1:0] mux_b;
    logic       mux_c;
    logic [1:0] t;
    logic       halted;
    logic       illegal;
  } cw_t;

  logic       clk;
  logic       rst;
  logic [1:0] t_o;
  logic       halted_o;
  logic       illegal_o;

  alu_system_control_unit_if bus_if ();

  alu_system_control_unit dut (
    .clk_i     (clk),
    .rst_i     (rst),
    .bus       (bus_if.master),
    .t_o       (t_o),
    .halted_o  (halted_o),
    .illegal_o (illegal_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  cw_t sb[$];
  int  checks = 0;
  int  errors = 0;
  int  cyc_id = 0;

  // Instruction-level reference state: cycle index within the 4-cycle instruction and halt status.
  int  m_phase  = 0;
  bit  m_halted = 1'b0;

  function automatic cw_t predict(input bit r, input bit h, input int p,
                                  input logic [15:0] ir, input logic [3:0] fl);
    cw_t        c;
    logic [3:0] op;
    logic [1:0] rd;
    logic [1:0] rs;
    c         = '0;
    c.rf_reg  = 4'hF;
    c.rf_scr  = 4'hF;
    c.arf_reg = 3'b111;
    c.mem_cs  = 1'b1;
    c.t       = 2'(p);
    c.halted  = h;
    op = ir[15:12];
    rd = ir[11:10];
    rs = ir[9:8];
    if (r) begin
      c.rf_reg  = 4'h0;
      c.rf_scr  = 4'h0;
      c.arf_reg = 3'b000;
      c.rf_fun  = 3'b011;
      c.arf_fun = 3'b011;
    end else if (!h) begin
      if (p == 0 || p == 1) begin
        c.mem_cs   = 1'b0;
        c.ir_write = 1'b1;
        c.ir_lh    = (p == 1);
        c.arf_reg  = 3'b011;
        c.arf_fun  = 3'b001;
      end else if (p == 3) begin
        case (op)
          4'h1: begin c.mux_a = 2'b11; c.rf_fun = 3'b010; c.rf_reg[rd] = 1'b0; end
          4'h2, 4'h3: begin
            c.rf_a = {1'b0, rd};
            c.rf_b = {1'b0, rs};
            c.alu_fun = (op == 4'h2) ? 5'b10100 : 5'b10101;
            c.alu_wf = 1'b1;
            c.rf_fun = 3'b010;
            c.rf_reg[rd] = 1'b0;
          end
          4'h4: if (fl[3] == 1'b0) begin
            c.mux_b = 2'b11; c.arf_fun = 3'b010; c.arf_reg = 3'b011;
          end
          4'h5: begin
            c.rf_a = {1'b0, rd}; c.alu_fun = 5'b10000;
            c.arf_d = 2'b10; c.mem_cs = 1'b0; c.mem_wr = 1'b1;
          end
          4'h6: begin
            c.arf_d = 2'b10; c.mem_cs = 1'b0; c.mux_a = 2'b10;
            c.rf_fun = 3'b010; c.rf_reg[rd] = 1'b0;
          end
          4'h7: begin c.mux_b = 2'b11; c.arf_fun = 3'b010; c.arf_reg = 3'b110; end
          4'h0, 4'hF: ;
          default: c.illegal = 1'b1;
        endcase
      end
    end
    return c;
  endfunction

  // One clock cycle: drive inputs, queue the predicted word, advance the model, then clock.
  task automatic step(input bit r, input logic [15:0] ir, input logic [3:0] fl);
    rst           = r;
    bus_if.ir_out = ir;
    bus_if.flags  = fl;
    sb.push_back(predict(r, m_halted, m_phase, ir, fl));
    if (r) begin
      m_phase  = 0;
      m_halted = 1'b0;
    end else if (!m_halted) begin
      if (m_phase == 3) begin
        if (ir[15:12] == 4'hF) m_halted = 1'b1;
        m_phase = 0;
      end else begin
        m_phase++;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic run_instr(input logic [15:0] ir, input logic [3:0] fl_exec, input bit rst_exec);
    step(1'b0, 16'($urandom), 4'($urandom));
    step(1'b0, 16'($urandom), 4'($urandom));
    step(1'b0, ir, 4'($urandom));
    step(rst_exec, ir, fl_exec);
  endtask

  task automatic rand_cycles(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 16'($urandom), 4'($urandom));
  endtask

  always @(negedge clk) begin
    cw_t act;
    cw_t exp_w;
    act = '{rf_a: bus_if.rf_out_a_sel, rf_b: bus_if.rf_out_b_sel, rf_fun: bus_if.rf_fun_sel,
            rf_reg: bus_if.rf_reg_sel, rf_scr: bus_if.rf_scr_sel, alu_fun: bus_if.alu_fun_sel,
            alu_wf: bus_if.alu_wf, arf_c: bus_if.arf_out_c_sel, arf_d: bus_if.arf_out_d_sel,
            arf_fun: bus_if.arf_fun_sel, arf_reg: bus_if.arf_reg_sel, ir_lh: bus_if.ir_lh,
            ir_write: bus_if.ir_write, mem_wr: bus_if.mem_wr, mem_cs: bus_if.mem_cs,
            mux_a: bus_if.mux_a_sel, mux_b: bus_if.mux_b_sel, mux_c: bus_if.mux_c_sel,
            t: t_o, halted: halted_o, illegal: illegal_o};
    if (sb.size() > 0) begin
      exp_w = sb.pop_front();
      checks++;
      if (act !== exp_w) begin
        errors++;
        $display("FAIL control_word cycle %0d: got %h expected %h (ir=%h flags=%h rst=%b)",
                 cyc_id, act, exp_w, bus_if.ir_out, bus_if.flags, rst);
      end
      checks++;
      if (bus_if.mem_wr === 1'b1 && (bus_if.ir_write !== 1'b0 || bus_if.mem_cs !== 1'b0)) begin
        errors++;
        $display("FAIL mem_wr_exclusive cycle %0d: got ir_write=%b mem_cs=%b expected 0,0",
                 cyc_id, bus_if.ir_write, bus_if.mem_cs);
      end
      cyc_id++;
    end
  end

  initial begin
    logic [15:0] ir;
    rst           = 1'b1;
    bus_if.ir_out = 16'h0000;
    bus_if.flags  = 4'h0;
    @(posedge clk);
    #1;

    // Two reset cycles, then the first fetch.
    step(1'b1, 16'($urandom), 4'($urandom));
    step(1'b1, 16'($urandom), 4'($urandom));

    // Directed instructions covering every defined opcode and both branch outcomes.
    run_instr(16'h1005, 4'h0, 1'b0);  // LDI R0,5
    run_instr(16'h1003, 4'h0, 1'b0);  // LDI R0,3
    run_instr(16'h14FF, 4'h0, 1'b0);  // LDI R1,-1
    run_instr(16'h2100, 4'h0, 1'b0);  // ADD R0,R1
    run_instr(16'h3100, 4'h8, 1'b0);  // SUB R0,R1
    run_instr(16'h40FC, 4'h0, 1'b0);  // BNE taken
    run_instr(16'h40FC, 4'h8, 1'b0);  // BNE not taken
    run_instr(16'h7040, 4'h0, 1'b0);  // LDAR 0x40
    run_instr(16'h187A, 4'h0, 1'b0);  // LDI R2,0x7A
    run_instr(16'h5800, 4'h0, 1'b0);  // ST R2
    run_instr(16'h6C00, 4'h0, 1'b0);  // LD R3
    run_instr(16'h0000, 4'h0, 1'b0);  // NOP
    run_instr(16'hA123, 4'h0, 1'b0);  // undefined opcode
    run_instr(16'hE3FF, 4'h0, 1'b0);  // undefined opcode

    // Random instruction stream, halt excluded so the stream keeps running.
    for (int i = 0; i < 40; i++) begin
      ir = 16'($urandom);
      ir[15:12] = 4'($urandom_range(0, 14));
      run_instr(ir, 4'($urandom), 1'b0);
    end

    // Reset arriving during the execute cycle of a store.
    run_instr(16'h5C00, 4'h0, 1'b1);
    run_instr(16'h1005, 4'h0, 1'b0);

    // Halt, stay halted for 20 cycles, then recover by reset.
    run_instr(16'hF000, 4'h0, 1'b0);
    rand_cycles(20);
    step(1'b1, 16'($urandom), 4'($urandom));
    run_instr(16'h2B00, 4'h0, 1'b0);
    run_instr(16'h4012, 4'h0, 1'b0);

    for (int i = 0; i < 10 && sb.size() != 0; i++) @(negedge clk);
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
